// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the data path. Only one transaction is outstanding at a time. Data
// requests win by default. A burst counter hands the memory to a waiting fetch
// after MAX_D_BURST consecutive data grants.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_D_BURST = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    if_req_i,
   input  logic [ADDR_WIDTH-1:0]   if_addr_i,
   output logic                    if_gnt_o,
   output logic                    if_rvalid_o,
   output logic [DATA_WIDTH-1:0]   if_rdata_o,
   input  logic                    d_req_i,
   input  logic                    d_we_i,
   input  logic [ADDR_WIDTH-1:0]   d_addr_i,
   input  logic [DATA_WIDTH-1:0]   d_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] d_be_i,
   output logic                    d_gnt_o,
   output logic                    d_rvalid_o,
   output logic [DATA_WIDTH-1:0]   d_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
   typedef enum logic {OWNER_IF, OWNER_D} owner_t;

   state_t state;
   owner_t owner;
   logic [3:0] burst_cnt;

   logic any_req;
   logic arb_cycle;
   logic pick_if;
   logic [3:0] next_cnt;
   logic sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BE_WIDTH-1:0] sel_be;
   logic if_owns_rsp;
   logic d_owns_rsp;

   // Decide whether this cycle arbitrates, who wins, what the winner's memory
   // command looks like, and where the burst counter goes afterwards.
   always_comb begin
      any_req   = if_req_i | d_req_i;
      arb_cycle = any_req & ((state == IDLE) | ((state == WAIT_RSP) & mem_rvalid_i));
      pick_if   = if_req_i & (~d_req_i | (burst_cnt == MAX_CNT));
      next_cnt  = 4'd0;
      if (if_req_i && !pick_if) begin
         next_cnt = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + 4'd1;
      end
      sel_we    = 1'b0;
      sel_addr  = if_addr_i;
      sel_wdata = '0;
      sel_be    = '1;
      if (!pick_if) begin
         sel_we    = d_we_i;
         sel_addr  = d_addr_i;
         sel_wdata = d_wdata_i;
         sel_be    = d_be_i;
      end
   end

   // Transaction FSM: registers the winner's command onto the memory port,
   // holds it until the memory grants, then waits for the single response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         owner       <= OWNER_IF;
         burst_cnt   <= 4'd0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
      end else if (arb_cycle) begin
         state       <= REQ;
         owner       <= pick_if ? OWNER_IF : OWNER_D;
         burst_cnt   <= next_cnt;
         mem_req_o   <= 1'b1;
         mem_we_o    <= sel_we;
         mem_addr_o  <= sel_addr;
         mem_wdata_o <= sel_wdata;
         mem_be_o    <= sel_be;
      end else begin
         case (state)
            REQ: begin
               if (mem_gnt_i) begin
                  state     <= WAIT_RSP;
                  mem_req_o <= 1'b0;
               end
            end
            WAIT_RSP: begin
               if (mem_rvalid_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Grants and responses are steered combinationally to whichever requester
   // owns the current transaction; the other side sees zeros.
   always_comb begin
      if_owns_rsp = (state == WAIT_RSP) & (owner == OWNER_IF);
      d_owns_rsp  = (state == WAIT_RSP) & (owner == OWNER_D);
      if_gnt_o    = mem_gnt_i & (state == REQ) & (owner == OWNER_IF);
      d_gnt_o     = mem_gnt_i & (state == REQ) & (owner == OWNER_D);
      if_rvalid_o = mem_rvalid_i & if_owns_rsp;
      d_rvalid_o  = mem_rvalid_i & d_owns_rsp;
      if_rdata_o  = if_owns_rsp ? mem_rdata_i : '0;
      d_rdata_o   = d_owns_rsp ? mem_rdata_i : '0;
   end

endmodule
